// File: rtl/tthbif_uart_rf.sv
// UART byte command decoder and lane tap-select register file for tthbif.
// Optional write acknowledge responses are enabled by defining TTHBIF_RF_WACK_EN.
module tthbif_uart_rf #(
    parameter int          NUM_LANES    = 1,
    parameter int          TIMEOUT_CLKS = 1000000,
    parameter logic [7:0]  ID_VALUE     = 8'hB1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     en_i,
    input  logic                     rx_data_valid_i,
    input  logic [7:0]               rx_data_i,
    input  logic                     tx_data_ready_i,
    output logic                     tx_data_valid_o,
    output logic [7:0]               tx_data_o,
    output logic [2*NUM_LANES-1:0]   comb_tap_sel_o,
    output logic [2*NUM_LANES-1:0]   flop_tap_sel_o
);

    localparam int CNT_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);

    localparam logic [6:0] ADDR_ID      = 7'h00;
    localparam logic [6:0] ADDR_STATUS  = 7'h01;
    localparam logic [6:0] ADDR_SCRATCH = 7'h02;
    localparam int         LANE_BASE    = 16;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DATA,
        SEND
    } state_t;

    state_t           state;
    logic [6:0]       addr_q;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       status;
    logic [7:0]       scratch;
    logic [3:0]       lane_cfg [NUM_LANES];
    logic [7:0]       rd_data;

    // Read data is decoded straight from the incoming command byte so it can
    // be captured in the same cycle the command is accepted.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        rd_data = 8'h00;
        case (rx_data_i[6:0])
            ADDR_ID:      rd_data = ID_VALUE;
            ADDR_STATUS:  rd_data = {6'b0, status};
            ADDR_SCRATCH: rd_data = scratch;
            default:      rd_data = 8'h00;
        endcase
        for (int n = 0; n < NUM_LANES; n++) begin
            if (rx_data_i[6:0] == 7'(LANE_BASE + n)) rd_data = {4'h0, lane_cfg[n]};
        end
    end

`ifdef TTHBIF_RF_WACK_EN
    localparam logic [7:0] RESP_ACK = 8'h06;
    localparam logic [7:0] RESP_NAK = 8'h15;

    logic wr_mapped;

    always_comb begin
        wr_mapped = (addr_q == ADDR_ID) || (addr_q == ADDR_STATUS) || (addr_q == ADDR_SCRATCH);
        for (int n = 0; n < NUM_LANES; n++) begin
            if (addr_q == 7'(LANE_BASE + n)) wr_mapped = 1'b1;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
            state           <= IDLE;
            tx_data_valid_o <= 1'b0;
            tx_data_o       <= 8'h00;
            addr_q          <= 7'h00;
            cnt             <= '0;
            status          <= 2'b00;
            scratch         <= 8'h00;
            // NOTE: lane_cfg is a small flop array with a defined reset value, not a RAM, so it is reset here.
            for (int n = 0; n < NUM_LANES; n++) lane_cfg[n] <= 4'hF;
        end else if (!en_i) begin
            state           <= IDLE;
            tx_data_valid_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_data_valid_i) begin
                        if (rx_data_i[7]) begin
                            addr_q <= rx_data_i[6:0];
                            cnt    <= '0;
                            state  <= WAIT_DATA;
                        end else begin
                            tx_data_o       <= rd_data;
                            tx_data_valid_o <= 1'b1;
                            state           <= SEND;
                        end
                    end
                end

                WAIT_DATA: begin
                    // A data byte in the expiry cycle takes priority over the timeout.
                    if (rx_data_valid_i) begin
                        if (addr_q == ADDR_STATUS)  status  <= status & ~rx_data_i[1:0];
                        if (addr_q == ADDR_SCRATCH) scratch <= rx_data_i;
                        for (int n = 0; n < NUM_LANES; n++) begin
                            if (addr_q == 7'(LANE_BASE + n)) lane_cfg[n] <= rx_data_i[3:0];
                        end
`ifdef TTHBIF_RF_WACK_EN
                        tx_data_o       <= wr_mapped ? RESP_ACK : RESP_NAK;
                        tx_data_valid_o <= 1'b1;
                        state           <= SEND;
`else
                        state           <= IDLE;
`endif
                    end else if (cnt == CNT_LAST) begin
                        status[1] <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                SEND: begin
                    if (rx_data_valid_i) status[0] <= 1'b1;
                    if (tx_data_ready_i) begin
                        tx_data_valid_o <= 1'b0;
                        state           <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    for (genvar n = 0; n < NUM_LANES; n++) begin : g_taps
        assign comb_tap_sel_o[2*n +: 2] = lane_cfg[n][1:0];
        assign flop_tap_sel_o[2*n +: 2] = lane_cfg[n][3:2];
    end

endmodule

// File: tb/tb_tthbif_uart_rf.sv
// Scoreboard bench for tthbif_uart_rf: expected tx bytes are queued by the
// stimulus and popped by an independent monitor on every tx handshake.
module tb_tthbif_uart_rf;

    localparam int NUM_LANES    = 2;
    localparam int TIMEOUT_CLKS = 16;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic [2*NUM_LANES-1:0] comb_tap;
    logic [2*NUM_LANES-1:0] flop_tap;

    int n_checks = 0;
    int n_errors = 0;
    int hs_count = 0;
    logic [7:0] exp_q [$];

    tthbif_uart_rf #(
        .NUM_LANES    (NUM_LANES),
        .TIMEOUT_CLKS (TIMEOUT_CLKS),
        .ID_VALUE     (8'hB1)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .en_i            (en),
        .rx_data_valid_i (rx_valid),
        .rx_data_i       (rx_data),
        .tx_data_ready_i (tx_ready),
        .tx_data_valid_o (tx_valid),
        .tx_data_o       (tx_data),
        .comb_tap_sel_o  (comb_tap),
        .flop_tap_sel_o  (flop_tap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a handshake occurs at the next rising edge when valid && ready here.
    always @(negedge clk) begin
        if (rst_n && tx_valid && tx_ready) begin
            hs_count++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_tx: got 0x%0h, expected no byte", tx_data);
            end else begin
                check("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: got %0d pending bytes, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic read_reg(input logic [6:0] addr, input logic [7:0] exp);
        exp_q.push_back(exp);
        send_byte({1'b0, addr});
        wait_drain();
    endtask

    // Leaves the bench right after the data pulse; the caller drains.
    task automatic write_reg(input logic [6:0] addr, input logic [7:0] data, input bit mapped);
        send_byte({1'b1, addr});
`ifdef TTHBIF_RF_WACK_EN
        exp_q.push_back(mapped ? 8'h06 : 8'h15);
`else
        if (mapped) begin end
`endif
        send_byte(data);
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish within cycle budget");
        $fatal(1);
    end

    initial begin
        logic stable;
        int   hs_before;

        rst_n    = 1'b0;
        en       = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_tx_data",  {24'h0, tx_data},  32'h0);
        check("rst_comb_tap", {28'h0, comb_tap}, 32'hF);
        check("rst_flop_tap", {28'h0, flop_tap}, 32'hF);
        rst_n = 1'b1;

        // Lane 0 config after reset
        read_reg(7'h10, 8'h0F);
        check("lane0_comb_reset", {30'h0, comb_tap[1:0]}, 32'h3);
        check("lane0_flop_reset", {30'h0, flop_tap[1:0]}, 32'h3);

        // Lane 0 write takes effect on the edge that samples the data byte
        write_reg(7'h10, 8'h06, 1'b1);
        check("lane0_comb_write", {30'h0, comb_tap[1:0]}, 32'h2);
        check("lane0_flop_write", {30'h0, flop_tap[1:0]}, 32'h1);
        check("lane1_untouched",  {28'h0, comb_tap[3:2], flop_tap[3:2]}, 32'hF);
        wait_drain();
        read_reg(7'h10, 8'h06);

        // ID read under backpressure, with an overrun byte during SEND
        tx_ready = 1'b0;
        exp_q.push_back(8'hB1);
        send_byte(8'h00);
        hs_before = hs_count;
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!tx_valid || tx_data !== 8'hB1) stable = 1'b0;
            if (i == 10) begin
                rx_valid = 1'b1;
                rx_data  = 8'h02;
            end
            if (i == 11) rx_valid = 1'b0;
        end
        check("send_stable", {31'h0, stable}, 32'h1);
        tx_ready = 1'b1;
        wait_drain();
        check("single_handshake", hs_count - hs_before, 32'h1);
        read_reg(7'h01, 8'h01);
        write_reg(7'h01, 8'h01, 1'b1);
        wait_drain();
        read_reg(7'h01, 8'h00);

        // Data byte in the expiry cycle wins over the timeout
        send_byte(8'h82);
        repeat (TIMEOUT_CLKS - 2) @(posedge clk);
`ifdef TTHBIF_RF_WACK_EN
        exp_q.push_back(8'h06);
`endif
        send_byte(8'h3C);
        wait_drain();
        read_reg(7'h01, 8'h00);
        read_reg(7'h02, 8'h3C);

        // Timeout: pending write discarded, sticky bit set, W1C clears it
        send_byte(8'h82);
        repeat (TIMEOUT_CLKS + 4) @(posedge clk);
        #1;
        check("timeout_no_valid", {31'h0, tx_valid}, 32'h0);
        read_reg(7'h01, 8'h02);
        read_reg(7'h02, 8'h3C);
        write_reg(7'h01, 8'h02, 1'b1);
        wait_drain();
        read_reg(7'h01, 8'h00);

        // Unmapped addresses
        write_reg(7'h7F, 8'h55, 1'b0);
        wait_drain();
        read_reg(7'h7F, 8'h00);
        read_reg(7'h12, 8'h00);
        read_reg(7'h11, 8'h0F);
        read_reg(7'h02, 8'h3C);

        // Reset while waiting for write data
        send_byte(8'h90);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_comb_tap", {28'h0, comb_tap}, 32'hF);
        check("midrst_flop_tap", {28'h0, flop_tap}, 32'hF);
        check("midrst_tx_valid", {31'h0, tx_valid}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        read_reg(7'h06, 8'h00);
        check("midrst_write_lost", {30'h0, comb_tap[1:0]}, 32'h3);

        // Disable during SEND, then rx bytes ignored while disabled
        tx_ready = 1'b0;
        send_byte(8'h00);
        @(negedge clk);
        check("en_send_valid", {31'h0, tx_valid}, 32'h1);
        @(posedge clk);
        #1;
        en = 1'b0;
        @(posedge clk);
        #1;
        check("en_off_valid", {31'h0, tx_valid}, 32'h0);
        tx_ready = 1'b1;
        send_byte(8'h00);
        send_byte(8'h90);
        send_byte(8'h0A);
        repeat (3) @(posedge clk);
        #1;
        check("en_off_no_tx",   {31'h0, tx_valid}, 32'h0);
        check("en_off_no_write", {28'h0, comb_tap[1:0], flop_tap[1:0]}, 32'hF);
        en = 1'b1;
        read_reg(7'h01, 8'h00);

        wait_drain();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tthbif_uart_rf.md
Name: tthbif_uart_rf

Overview:
Byte-oriented command decoder and small register file between the UART RX/TX byte interface and the tthbif lanes. It sequences single-byte read/write commands received over UART and drives the per-lane comb/flop tap selects. For reads and optional write acknowledges it returns response bytes through the UART TX valid/ready handshake. Sits in the tthbif top between u_uart and the g_lanes generate block.

Parameters:
NUM_LANES, 1, number of lanes with a config register (1..16)
TIMEOUT_CLKS, 1000000, clocks allowed between command byte and data byte of a write
ID_VALUE, 8'hB1, read-only ID register value

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset; asynchronous, active-low
en_i  input  1  block enable
rx_data_valid_i  input  1  1-cycle pulse, UART byte received
rx_data_i  input  8  received byte, valid with rx_data_valid_i
tx_data_ready_i  input  1  UART TX can accept a byte
tx_data_valid_o  output  1  response byte valid
tx_data_o  output  8  response byte
comb_tap_sel_o  output  2*NUM_LANES  lane n comb tap select at [2n+1:2n]
flop_tap_sel_o  output  2*NUM_LANES  lane n flop tap select at [2n+1:2n]

Behaviour:
- Command byte: bit7=1 write, bit7=0 read; bits[6:0] = address. A write is followed by one data byte.
- Register map:
  - 0x00 ID: RO = ID_VALUE
  - 0x01 STATUS: bit0 overrun sticky, bit1 timeout sticky; write-1-to-clear; other bits read 0
  - 0x02 SCRATCH: RW 8-bit, reset 0x00
  - 0x10+n, n<NUM_LANES, LANE_CFG: bits[1:0] comb_tap_sel, bits[3:2] flop_tap_sel, bits[7:4] read 0; reset 0x0F
  - Unmapped addresses: reads return 0x00, writes ignored
- Reset values: tx_data_valid_o=0, tx_data_o=0x00, all tap selects 2'b11, STATUS=0, FSM=IDLE.
- FSM states: IDLE, WAIT_DATA, SEND.
  - IDLE: on an rx byte with bit7=0, latch read data into tx_data_o and go to SEND; tx_data_valid_o=1 on the next cycle. On an rx byte with bit7=1, latch the address, clear the timeout counter and go to WAIT_DATA.
  - WAIT_DATA: on an rx byte, perform the write and return to IDLE. The register updates, and the outputs change, on the cycle after the data byte's valid pulse. The counter increments every cycle. When it reaches TIMEOUT_CLKS-1 with no rx byte, set STATUS.bit1, discard the pending write and go to IDLE. An rx byte in the expiry cycle wins: the write completes and no timeout is flagged.
  - SEND: hold tx_data_valid_o and tx_data_o stable until tx_data_valid_o && tx_data_ready_i, then drop valid and go to IDLE on the next cycle. An rx byte arriving in SEND is dropped and sets STATUS.bit0.
- Read data is sampled when the command is accepted. A read of STATUS returns the value before any clear.
- en_i=0: FSM forced to IDLE, tx_data_valid_o cleared, rx bytes ignored (no sticky bits set). Registers and tap outputs hold their values.
- Reset mid-operation (any state): immediately return to the reset values above; any pending write is lost.
- Tap outputs are driven directly from registers, with no combinational path from the rx inputs.

Optional Feature:
Macro TTHBIF_RF_WACK_EN.
- Defined: every completed write enters SEND with response 0x06 (ACK) for mapped addresses (including RO ID) or 0x15 (NAK) for unmapped addresses. A write timeout produces no response.
- Undefined: writes produce no response byte; the FSM goes WAIT_DATA -> IDLE.

Test Plan:
- Reset, then read 0x10 with tx_data_ready_i=1 -> one tx byte 0x0F; comb/flop_tap_sel_o lane0 = 2'b11.
- Write 0x90 then 0x06 -> comb_tap_sel_o[1:0]=2'b10 and flop_tap_sel_o[1:0]=2'b01 one cycle after the data pulse; read 0x10 returns 0x06. With WACK_EN, a 0x06 ACK precedes the read response.
- Read 0x00 with tx_data_ready_i held low 50 cycles -> tx_data_valid_o=1 and tx_data_o=0xB1 stable throughout; single handshake when ready rises; extra rx byte during the wait -> STATUS reads 0x01.
- Write command 0x82 with no data for TIMEOUT_CLKS (set 16 in the bench) -> FSM back to IDLE, SCRATCH unchanged, STATUS reads 0x02; write 0x81,0x02 -> STATUS reads 0x00.
- Write 0xFF,0x55 (unmapped) -> no register change; read 0x7F returns 0x00; with WACK_EN the write response is 0x15.
- Assert rst_ni low while in WAIT_DATA after 0x90 -> taps 2'b11 and tx_data_valid_o=0. Drive en_i=0 during a read's SEND -> valid drops and subsequent rx bytes are ignored.
